approx_add_err_sequencer: RTL and testbench

//  Sequences a batch of signed operand pairs through an external combinational

---
 rtl/approx_add_err_sequencer_pkg.sv | 42 ++++
 rtl/approx_add_err_sequencer_if.sv | 45 ++++
 rtl/approx_add_err_sequencer_err_accum.sv | 72 +++++++
 rtl/approx_add_err_sequencer.sv | 165 ++++++++++++++++
 tb/tb_approx_add_err_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_add_err_sequencer_pkg.sv
// Shared types, default widths and the saturating-add helper for the
// approximate-adder error sequencer.
package approx_add_err_sequencer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 32;
    localparam int ACC_W_DEF = 100;

    // Working width of sat_add; must cover ACC_W and the 2*WIDTH+2 square.
    localparam int SAT_W = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Adds two unsigned values and clamps the result to all-ones of width w.
    // The accumulator operand is already below the clamp; the increment may
    // exceed it (a wide square into a narrow accumulator) and still clamps.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int               w
    );
        logic [SAT_W:0]   sum;
        logic [SAT_W-1:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        if (w >= SAT_W) begin
            lim = '1;
        end else begin
            lim = (SAT_W'(1) << w) - SAT_W'(1);
        end
        if (sum > {1'b0, lim}) begin
            sat_add = lim;
        end else begin
            sat_add = sum[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/approx_add_err_sequencer_if.sv
// Bundle of the operand stream, external adder link, result stream and
// statistics readout. The sequencer uses the slave side; the operand
// source / adder / readout environment uses the master side.
interface approx_add_err_sequencer_if
    import approx_add_err_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) ();

    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_sum;
    logic             out_valid;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_appx;
    logic [WIDTH-1:0] out_accr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   max_ae;
    logic [ACC_W-1:0] sae;
    logic [ACC_W-1:0] sse;

    modport slave (
        input  start, num_samples, in_valid, in_a, in_b, add_sum,
        output in_ready, add_a, add_b, out_valid, out_a, out_b,
               out_appx, out_accr, busy, done, count, max_ae, sae, sse
    );

    modport master (
        output start, num_samples, in_valid, in_a, in_b, add_sum,
        input  in_ready, add_a, add_b, out_valid, out_a, out_b,
               out_appx, out_accr, busy, done, count, max_ae, sae, sse
    );

endinterface

// File: rtl/approx_add_err_sequencer_err_accum.sv
// Error statistics for completed samples: absolute error, its square,
// saturating sums of both, running maximum and the sample count.
module approx_add_err_sequencer_err_accum
    import approx_add_err_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_appx,
    input  logic [WIDTH-1:0] i_accr,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH:0]   o_max_ae,
    output logic [ACC_W-1:0] o_sae,
    output logic [ACC_W-1:0] o_sse
);

    localparam int SQ_W = 2 * WIDTH + 2;

    logic [WIDTH:0]   w_err;
    logic [WIDTH:0]   w_ae;
    logic [SQ_W-1:0]  w_aeWide;
    logic [SQ_W-1:0]  w_aeSq;
    logic [ACC_W-1:0] w_saeNext;
    logic [ACC_W-1:0] w_sseNext;

    logic [CNT_W-1:0] r_count;
    logic [WIDTH:0]   r_maxAe;
    logic [ACC_W-1:0] r_sae;
    logic [ACC_W-1:0] r_sse;

    // Signed difference in one extra bit can never overflow, so its
    // magnitude always fits in WIDTH+1 unsigned bits.
    assign w_err     = {i_appx[WIDTH-1], i_appx} - {i_accr[WIDTH-1], i_accr};
    assign w_ae      = w_err[WIDTH] ? -w_err : w_err;
    assign w_aeWide  = {{(WIDTH + 1){1'b0}}, w_ae};
    assign w_aeSq    = w_aeWide * w_aeWide;
    assign w_saeNext = ACC_W'(sat_add(SAT_W'(r_sae), SAT_W'(w_ae), ACC_W));
    assign w_sseNext = ACC_W'(sat_add(SAT_W'(r_sse), SAT_W'(w_aeSq), ACC_W));

    // Statistics clear on a new batch and update once per completed sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_maxAe <= '0;
            r_sae   <= '0;
            r_sse   <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_maxAe <= '0;
            r_sae   <= '0;
            r_sse   <= '0;
        end else if (i_valid) begin
            r_count <= r_count + CNT_W'(1);
            if (w_ae > r_maxAe) begin
                r_maxAe <= w_ae;
            end
            r_sae <= w_saeNext;
            r_sse <= w_sseNext;
        end
    end

    assign o_count  = r_count;
    assign o_max_ae = r_maxAe;
    assign o_sae    = r_sae;
    assign o_sse    = r_sse;

endmodule

// File: rtl/approx_add_err_sequencer.sv
// Batch sequencer: accepts operand pairs, drives them through the external
// approximate adder, pairs the result with the exact sum and streams both
// out while the error statistics accumulate.
module approx_add_err_sequencer
    import approx_add_err_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    approx_add_err_sequencer_if.slave     io_bus
);

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_remaining;

    logic             w_startOk;
    logic             w_accept;
    logic             w_lastAccept;
    logic             w_inReady;
    logic             w_busy;
    logic             w_done;
    logic             w_unused_carry;

    logic             r_s1Valid;
    logic [WIDTH-1:0] r_s1A;
    logic [WIDTH-1:0] r_s1B;

    logic             r_s2Valid;
    logic [WIDTH-1:0] r_s2A;
    logic [WIDTH-1:0] r_s2B;
    logic [WIDTH-1:0] r_s2Appx;
    logic [WIDTH-1:0] r_s2Accr;

    // start is honoured only when no batch is in flight.
    assign w_startOk      = io_bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept       = io_bus.in_valid && (r_state == RUN);
    assign w_lastAccept   = w_accept && (r_remaining == CNT_W'(1));
    assign w_unused_carry = io_bus.add_sum[WIDTH];

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Pairs still to accept in the current batch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_remaining <= '0;
        end else if (w_startOk) begin
            r_remaining <= io_bus.num_samples;
        end else if (w_accept) begin
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // Next state and the state-decoded handshake/status outputs.
    always_comb begin
        w_stateNext = r_state;
        w_inReady   = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startOk) begin
                    w_stateNext = (io_bus.num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_inReady = 1'b1;
                w_busy    = 1'b1;
                if (w_lastAccept) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (r_s2Valid && !r_s1Valid) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                if (w_startOk) begin
                    w_stateNext = (io_bus.num_samples == '0) ? DONE : RUN;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Stage 1: accepted operands, held on the approximate adder inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1A     <= '0;
            r_s1B     <= '0;
        end else begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1A <= io_bus.in_a;
                r_s1B <= io_bus.in_b;
            end
        end
    end

    // Stage 2: approximate and exact sums captured side by side.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2Valid <= 1'b0;
            r_s2A     <= '0;
            r_s2B     <= '0;
            r_s2Appx  <= '0;
            r_s2Accr  <= '0;
        end else begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2A    <= r_s1A;
                r_s2B    <= r_s1B;
                r_s2Appx <= io_bus.add_sum[WIDTH-1:0];
                r_s2Accr <= r_s1A + r_s1B;
            end
        end
    end

    approx_add_err_sequencer_err_accum #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) u_errAccum (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_startOk),
        .i_valid  (r_s2Valid),
        .i_appx   (r_s2Appx),
        .i_accr   (r_s2Accr),
        .o_count  (io_bus.count),
        .o_max_ae (io_bus.max_ae),
        .o_sae    (io_bus.sae),
        .o_sse    (io_bus.sse)
    );

    assign io_bus.in_ready  = w_inReady;
    assign io_bus.busy      = w_busy;
    assign io_bus.done      = w_done;
    assign io_bus.add_a     = r_s1A;
    assign io_bus.add_b     = r_s1B;
    assign io_bus.out_valid = r_s2Valid;
    assign io_bus.out_a     = r_s2A;
    assign io_bus.out_b     = r_s2B;
    assign io_bus.out_appx  = r_s2Appx;
    assign io_bus.out_accr  = r_s2Accr;

endmodule

// File: tb/tb_approx_add_err_sequencer.sv
// Bench for the approximate-adder error sequencer: stub adders with selectable
// error, table-driven batches checked through a scoreboard, and hand-written
// sequences for start/reset/saturation corner cases.
module tb_approx_add_err_sequencer;

    localparam int W    = 32;
    localparam int CW   = 32;
    localparam int AW   = 100;
    localparam int AW64 = 64;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expAppx;
        logic [W-1:0] expAccr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   stubMode = 0;
    int   cyc = 0;
    int   lastOutCyc = 0;
    int   nChecks = 0;
    int   nPass = 0;

    vec_t vecs[$];
    vec_t expQ[$];
    int   accQ[$];

    always #5 clk = ~clk;

    // Free-running cycle index, advanced on the active edge only.
    always @(posedge clk) cyc <= cyc + 1;

    approx_add_err_sequencer_if #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW))   bus ();
    approx_add_err_sequencer_if #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW64)) bus64 ();

    approx_add_err_sequencer #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    approx_add_err_sequencer #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW64)) dut64 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus64)
    );

    // Stub approximate adder: 0 exact, 1 forces bit0, 2 flips bit W-1 (error 2^(W-1)).
    function automatic logic [W:0] stubAdd(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (mode == 1) s[0] = 1'b1;
        if (mode == 2) s[W-1] = ~s[W-1];
        return s;
    endfunction

    assign bus.add_sum   = stubAdd(bus.add_a, bus.add_b, stubMode);
    assign bus64.add_sum = stubAdd(bus64.add_a, bus64.add_b, stubMode);

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void addVec(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] appx, input logic [W-1:0] accr);
        vec_t v;
        v.a = a;
        v.b = b;
        v.expAppx = appx;
        v.expAccr = accr;
        vecs.push_back(v);
    endfunction

    // Scoreboard monitor: records accept cycles, pops expectations on out_valid.
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (expQ.size() == 0 || accQ.size() == 0) begin
                checkOutput("out_valid with empty scoreboard", 1, 0);
            end else begin
                vec_t e;
                int   ac;
                e  = expQ.pop_front();
                ac = accQ.pop_front();
                checkOutput("out_a", bus.out_a, e.a);
                checkOutput("out_b", bus.out_b, e.b);
                checkOutput("out_appx", bus.out_appx, e.expAppx);
                checkOutput("out_accr", bus.out_accr, e.expAccr);
                checkOutput("accept to out_valid latency", cyc - ac, 2);
            end
            lastOutCyc = cyc;
        end
        if (bus.in_valid && bus.in_ready) accQ.push_back(cyc);
    end

    // Starts a batch from vecs, optionally pulsing start mid-batch, and
    // drives at most stopAfter pairs.
    task automatic applyStimulus(input int glitchAt, input int stopAfter);
        bus.num_samples = CW'(vecs.size());
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < vecs.size() && i < stopAfter; i++) begin
            int w;
            expQ.push_back(vecs[i]);
            bus.in_valid = 1'b1;
            bus.in_a = vecs[i].a;
            bus.in_b = vecs[i].b;
            if (i == glitchAt) begin
                bus.start = 1'b1;
                bus.num_samples = 1;
            end
            w = 0;
            @(negedge clk);
            while (!bus.in_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (w >= 20) checkOutput("in_ready timeout", 0, 1);
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDone(input bit expectOut, output int waited);
        int w;
        bit found;
        bit prevBusy;
        w = 0;
        found = 1'b0;
        prevBusy = 1'b0;
        while (!found && w < 60) begin
            @(negedge clk);
            if (bus.done) found = 1'b1;
            else begin
                prevBusy = bus.busy;
                w++;
            end
        end
        waited = w;
        checkOutput("done pulse seen", found, 1);
        if (found) begin
            checkOutput("busy low with done", bus.busy, 0);
            if (expectOut) begin
                checkOutput("busy high before done", prevBusy, 1);
                checkOutput("done 1 cycle after last out_valid", cyc - lastOutCyc, 1);
            end
            checkOutput("scoreboard drained at done", expQ.size(), 0);
            @(negedge clk);
            checkOutput("done one-cycle pulse", bus.done, 0);
        end
    endtask

    task automatic checkStats(input logic [CW-1:0] cnt, input logic [W:0] mx,
                              input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        checkOutput("count", bus.count, cnt);
        checkOutput("max_ae", bus.max_ae, mx);
        checkOutput("sae", bus.sae, s1);
        checkOutput("sse", bus.sse, s2);
    endtask

    initial begin
        int waited;
        int k;
        int readyCnt;
        int doneCnt;
        bit prevBusy;
        bit acc;
        int nOut;
        int nReady;
        bit seenDone;

        bus.start = 0; bus.num_samples = 0; bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0;
        bus64.start = 0; bus64.num_samples = 0; bus64.in_valid = 0; bus64.in_a = 0; bus64.in_b = 0;

        // Reset state.
        #12;
        checkOutput("reset in_ready", bus.in_ready, 0);
        checkOutput("reset out_valid", bus.out_valid, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset count", bus.count, 0);
        checkOutput("reset sse", bus.sse, 0);
        #6 rst_n = 1'b1;
        @(posedge clk); #1;

        // Exact adder, four pairs including the signed overflow case.
        stubMode = 0;
        vecs.delete();
        addVec(32'd1, 32'd2, 32'd3, 32'd3);
        addVec(32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        addVec(32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'h8000_0000);
        addVec(32'd0, 32'd0, 32'd0, 32'd0);
        applyStimulus(-1, 99);
        waitDone(1'b1, waited);
        checkStats(4, 0, 0, 0);

        // Bit0-forcing adder, single sample: error of one.
        stubMode = 1;
        vecs.delete();
        addVec(32'd2, 32'd2, 32'd5, 32'd4);
        applyStimulus(-1, 99);
        waitDone(1'b1, waited);
        checkStats(1, 1, 1, 1);

        // Error 2^31 on every sample, in_valid held high throughout.
        stubMode = 2;
        vecs.delete();
        addVec(32'd1, 32'd2, 32'h8000_0003, 32'd3);
        addVec(32'hFFFF_FFFB, 32'd3, 32'h7FFF_FFFE, 32'hFFFF_FFFE);
        addVec(32'h7FFF_FFFF, 32'd1, 32'h0000_0000, 32'h8000_0000);
        foreach (vecs[i]) expQ.push_back(vecs[i]);
        bus.num_samples = 3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        k = 0; readyCnt = 0; doneCnt = 0; prevBusy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bus.in_a = (k < 3) ? vecs[k].a : 32'h0000_0BAD;
            bus.in_b = (k < 3) ? vecs[k].b : 32'h0000_0BAD;
            @(negedge clk);
            acc = bus.in_ready;
            if (bus.in_ready) readyCnt++;
            if (bus.done) begin
                doneCnt++;
                checkOutput("busy low as done rises", bus.busy, 0);
                checkOutput("busy high before done", prevBusy, 1);
                checkOutput("done right after last out_valid", cyc - lastOutCyc, 1);
            end
            prevBusy = bus.busy;
            @(posedge clk); #1;
            if (acc) k++;
        end
        bus.in_valid = 1'b0;
        checkOutput("in_ready high cycles", readyCnt, 3);
        checkOutput("done pulse count", doneCnt, 1);
        checkStats(3, 33'h0_8000_0000, 100'h1_8000_0000, 100'hC000_0000_0000_0000);

        // start during RUN is ignored; then num_samples=0 completes at once.
        stubMode = 1;
        vecs.delete();
        addVec(32'd10, 32'd20, 32'd31, 32'd30);
        addVec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        addVec(32'd6, 32'd0, 32'd7, 32'd6);
        applyStimulus(1, 99);
        waitDone(1'b1, waited);
        checkStats(3, 1, 3, 3);
        vecs.delete();
        applyStimulus(-1, 99);
        waitDone(1'b0, waited);
        checkOutput("zero batch done next cycle", waited, 0);
        checkStats(0, 0, 0, 0);

        // Reset mid-batch after two accepts, then a clean batch.
        stubMode = 0;
        vecs.delete();
        addVec(32'd1, 32'd2, 32'd3, 32'd3);
        addVec(32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        addVec(32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'h8000_0000);
        addVec(32'd0, 32'd0, 32'd0, 32'd0);
        applyStimulus(-1, 2);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", bus.out_valid, 0);
        checkOutput("abort in_ready", bus.in_ready, 0);
        checkOutput("abort busy", bus.busy, 0);
        checkOutput("abort add_a", bus.add_a, 0);
        checkOutput("abort out_accr", bus.out_accr, 0);
        expQ.delete();
        accQ.delete();
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(-1, 99);
        waitDone(1'b1, waited);
        checkStats(4, 0, 0, 0);

        // 64-bit accumulators: five 2^62 squares must clamp, not wrap.
        stubMode = 2;
        bus64.num_samples = 5;
        bus64.in_a = 0;
        bus64.in_b = 0;
        bus64.start = 1'b1;
        @(posedge clk); #1;
        bus64.start = 1'b0;
        bus64.in_valid = 1'b1;
        nOut = 0; nReady = 0; seenDone = 1'b0;
        for (int c = 0; c < 30 && !seenDone; c++) begin
            @(negedge clk);
            if (bus64.out_valid) nOut++;
            if (bus64.in_ready) nReady++;
            if (bus64.done) seenDone = 1'b1;
        end
        bus64.in_valid = 1'b0;
        checkOutput("sat done seen", seenDone, 1);
        checkOutput("sat out_valid pulses", nOut, 5);
        checkOutput("sat accepts", nReady, 5);
        checkOutput("sat count", bus64.count, 5);
        checkOutput("sat max_ae", bus64.max_ae, 33'h0_8000_0000);
        checkOutput("sat sae", bus64.sae, 64'h2_8000_0000);
        checkOutput("sat sse", bus64.sse, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
